// File: rtl/nh_lcd_cmd_sequencer.sv
// Script-driven LCD transaction sequencer: buffers {type,data} entries in a FWFT FIFO
// and replays them to the LCD command block with delay, timeout, read-back and abort.
module nh_lcd_cmd_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DELAY_UNIT = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [1:0]            i_push_type,
  input  logic [7:0]            i_push_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_overflow,
  output logic [7:0]            o_rd_data,
  output logic                  o_rd_stb,
  output logic                  o_cmd_write_stb,
  output logic                  o_cmd_read_stb,
  output logic [7:0]            o_cmd_data,
  output logic                  o_cmd_parameter,
  output logic                  o_enable,
  input  logic [7:0]            i_cmd_data,
  input  logic                  i_cmd_finished
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DLY_W = 8 + $clog2(DELAY_UNIT);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_FIN, S_DELAY, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [9:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr_q, rdPtr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [9:0]            head;
  logic                  pushOk, pop, flush, abortActive, timeoutHit, startOk;

  logic [1:0]            curType_q;
  logic [7:0]            cmdData_q;
  logic                  cmdParam_q;
  logic [DLY_W-1:0]      dly_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [7:0]            rdData_q;
  logic                  rdStb_q, error_q, overflow_q;

  assign head        = mem_q[rdPtr_q];
  assign o_full      = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty     = (count_q == '0);
  assign o_count     = count_q;
  assign pushOk      = i_push && !o_full;
  assign abortActive = i_abort && (state_q inside {S_FETCH, S_ISSUE, S_WAIT_FIN, S_DELAY});
  assign timeoutHit  = (state_q == S_WAIT_FIN) && !i_cmd_finished && !i_abort &&
                       (tmo_q == TMO_W'(TIMEOUT - 1));
  assign flush       = abortActive || timeoutHit;
  assign pop         = (state_q == S_FETCH) && !abortActive;
  assign startOk     = (state_q == S_IDLE) && i_start;

  // A flush that coincides with a push keeps the new entry as the only one queued.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = pushOk ? (ADDR_WIDTH+1)'(1) : '0;
    end else begin
      count_d = count_q + (ADDR_WIDTH+1)'(pushOk) - (ADDR_WIDTH+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[flush ? '0 : wrPtr_q] <= {i_push_type, i_push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = o_empty ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (head[9:8] != 2'd3)      state_d = S_ISSUE;
        else if (head[7:0] != 8'd0) state_d = S_DELAY;
        else                        state_d = (count_d != '0) ? S_FETCH : S_DONE;
      end
      S_ISSUE: state_d = S_WAIT_FIN;
      S_WAIT_FIN: begin
        if (i_cmd_finished)  state_d = (count_d != '0) ? S_FETCH : S_DONE;
        else if (timeoutHit) state_d = S_DONE;
      end
      S_DELAY: begin
        if (dly_q == DLY_W'(1)) state_d = (count_d != '0) ? S_FETCH : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abortActive) state_d = S_DONE;
  end

  always_comb begin
    o_busy          = (state_q != S_IDLE);
    o_enable        = (state_q != S_IDLE);
    o_done          = (state_q == S_DONE);
    o_cmd_write_stb = (state_q == S_ISSUE) && (curType_q != 2'd2);
    o_cmd_read_stb  = (state_q == S_ISSUE) && (curType_q == 2'd2);
  end

  assign o_cmd_data      = cmdData_q;
  assign o_cmd_parameter = cmdParam_q;
  assign o_rd_data       = rdData_q;
  assign o_rd_stb        = rdStb_q;
  assign o_error         = error_q;
  assign o_overflow      = overflow_q;

  // Command outputs are only reloaded for bus entries so they hold across delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      curType_q  <= 2'd0;
      cmdData_q  <= 8'd0;
      cmdParam_q <= 1'b0;
      dly_q      <= '0;
      tmo_q      <= '0;
      rdData_q   <= 8'd0;
      rdStb_q    <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wrPtr_q <= pushOk ? ADDR_WIDTH'(1) : '0;
        rdPtr_q <= '0;
      end else begin
        if (pushOk) wrPtr_q <= wrPtr_q + ADDR_WIDTH'(1);
        if (pop)    rdPtr_q <= rdPtr_q + ADDR_WIDTH'(1);
      end

      if (pop) begin
        curType_q <= head[9:8];
        if (head[9:8] != 2'd3) begin
          cmdData_q  <= head[7:0];
          cmdParam_q <= (head[9:8] == 2'd1);
        end else begin
          dly_q <= DLY_W'(head[7:0]) * DLY_W'(DELAY_UNIT);
        end
      end else if (state_q == S_DELAY) begin
        dly_q <= dly_q - DLY_W'(1);
      end

      if (state_q == S_ISSUE)         tmo_q <= '0;
      else if (state_q == S_WAIT_FIN) tmo_q <= tmo_q + TMO_W'(1);

      rdStb_q <= 1'b0;
      if ((state_q == S_WAIT_FIN) && i_cmd_finished && !i_abort && (curType_q == 2'd2)) begin
        rdData_q <= i_cmd_data;
        rdStb_q  <= 1'b1;
      end

      if (timeoutHit)   error_q <= 1'b1;
      else if (startOk) error_q <= 1'b0;

      if (i_push && o_full) overflow_q <= 1'b1;
      else if (startOk)     overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nh_lcd_cmd_sequencer.sv
// Randomized bench for nh_lcd_cmd_sequencer: a responder stands in for the LCD command block
// and a script-level timing model predicts every strobe, read-back and done pulse.
module tb_nh_lcd_cmd_sequencer;
  localparam int AW    = 4;
  localparam int DU    = 16;
  localparam int TMO   = 255;
  localparam int DEPTH = 1 << AW;

  typedef struct { int c; bit rd; bit [7:0] d; bit p; } txn_t;
  typedef struct { int c; bit [7:0] d; } rdev_t;
  typedef struct { bit [1:0] t; bit [7:0] d; } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_push = 1'b0, i_start = 1'b0, i_abort = 1'b0;
  logic [1:0] i_push_type = 2'd0;
  logic [7:0] i_push_data = 8'd0;
  logic o_full, o_empty, o_busy, o_done, o_error, o_overflow, o_rd_stb;
  logic o_cmd_write_stb, o_cmd_read_stb, o_cmd_parameter, o_enable;
  logic [AW:0] o_count;
  logic [7:0] o_rd_data, o_cmd_data;
  logic [7:0] i_cmd_data;
  logic i_cmd_finished;

  logic respFin = 1'b0, forceFin = 1'b0;
  logic [7:0] respData = 8'd0, forceData = 8'd0;
  bit respEnable = 1'b1;
  int lat = 2;
  int pendCnt = 0;
  logic [7:0] readVals[$];

  assign i_cmd_finished = respFin | forceFin;
  assign i_cmd_data     = forceFin ? forceData : respData;

  int cyc = 0;
  int vectors = 0, miscompares = 0;
  txn_t obsTxn[$], expTxn[$];
  rdev_t obsRd[$], expRd[$];
  int obsDone[$];
  int expDone;
  txn_t tmpT;

  nh_lcd_cmd_sequencer #(.ADDR_WIDTH(AW), .DELAY_UNIT(DU), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_push(i_push), .i_push_type(i_push_type), .i_push_data(i_push_data),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_overflow(o_overflow),
    .o_rd_data(o_rd_data), .o_rd_stb(o_rd_stb),
    .o_cmd_write_stb(o_cmd_write_stb), .o_cmd_read_stb(o_cmd_read_stb),
    .o_cmd_data(o_cmd_data), .o_cmd_parameter(o_cmd_parameter), .o_enable(o_enable),
    .i_cmd_data(i_cmd_data), .i_cmd_finished(i_cmd_finished)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder finishes each transaction lat cycles after its strobe; also logs DUT events.
  always @(negedge clk) begin
    respFin = 1'b0;
    if (pendCnt > 0) begin
      pendCnt = pendCnt - 1;
      if (pendCnt == 0) respFin = 1'b1;
    end
    if (rst_n) begin
      if (o_cmd_write_stb || o_cmd_read_stb) begin
        tmpT.c  = cyc;
        tmpT.rd = o_cmd_read_stb;
        tmpT.d  = o_cmd_write_stb ? o_cmd_data : 8'd0;
        tmpT.p  = o_cmd_write_stb ? o_cmd_parameter : 1'b0;
        obsTxn.push_back(tmpT);
        if (respEnable) begin
          pendCnt = lat;
          if (o_cmd_read_stb) respData = (readVals.size() > 0) ? readVals.pop_front() : 8'hA5;
        end
      end
      if (o_rd_stb) obsRd.push_back('{cyc, o_rd_data});
      if (o_done)   obsDone.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic [1:0] t, input logic [7:0] d,
                               input logic start, input logic abort);
    @(negedge clk);
    i_push = push; i_push_type = t; i_push_data = d; i_start = start; i_abort = abort;
  endtask

  function automatic ent_t mk(input bit [1:0] t, input bit [7:0] d);
    ent_t e;
    e.t = t; e.d = d;
    return e;
  endfunction

  // Timeline from the script: FETCH slot, then ISSUE+lat wait for bus entries, c*DU for delays.
  task automatic buildModel(input ent_t s[$], input int n0, input int l, input logic [7:0] rv[$]);
    int t = n0 + 1;
    int ri = 0;
    txn_t x;
    expTxn.delete(); expRd.delete();
    foreach (s[i]) begin
      if (s[i].t == 2'd3) begin
        t += (s[i].d == 0) ? 1 : 1 + int'(s[i].d) * DU;
      end else begin
        x.c = t + 1; x.rd = (s[i].t == 2'd2);
        x.d = x.rd ? 8'd0 : s[i].d; x.p = (s[i].t == 2'd1);
        expTxn.push_back(x);
        if (x.rd) begin
          expRd.push_back('{t + 2 + l, rv[ri]});
          ri++;
        end
        t += 2 + l;
      end
    end
    expDone = t;
  endtask

  task automatic compareRun(input string tag);
    checkOutput({tag, "_ntxn"}, obsTxn.size(), expTxn.size());
    for (int i = 0; i < obsTxn.size() && i < expTxn.size(); i++) begin
      checkOutput({tag, "_txn_cyc"}, obsTxn[i].c, expTxn[i].c);
      checkOutput({tag, "_txn_kind"}, {obsTxn[i].rd, obsTxn[i].p, obsTxn[i].d},
                  {expTxn[i].rd, expTxn[i].p, expTxn[i].d});
    end
    checkOutput({tag, "_nrd"}, obsRd.size(), expRd.size());
    for (int i = 0; i < obsRd.size() && i < expRd.size(); i++) begin
      checkOutput({tag, "_rd_cyc"}, obsRd[i].c, expRd[i].c);
      checkOutput({tag, "_rd_data"}, obsRd[i].d, expRd[i].d);
    end
    checkOutput({tag, "_ndone"}, obsDone.size(), 1);
    if (obsDone.size() > 0) checkOutput({tag, "_done_cyc"}, obsDone[0], expDone);
  endtask

  task automatic clearObs();
    obsTxn.delete(); obsRd.delete(); obsDone.delete();
  endtask

  task automatic waitDone(output int n0);
    applyStimulus(0, 2'd0, 8'd0, 1, 0);
    n0 = cyc;
    for (int k = 0; k < 6000 && obsDone.size() == 0; k++) applyStimulus(0, 2'd0, 8'd0, 0, 0);
    repeat (2) applyStimulus(0, 2'd0, 8'd0, 0, 0);
  endtask

  task automatic runScript(input string tag, input ent_t s[$], input int l, input logic [7:0] firstRd);
    logic [7:0] rv[$];
    int n0;
    foreach (s[i]) if (s[i].t == 2'd2) rv.push_back((rv.size() == 0) ? firstRd : 8'($urandom));
    readVals = rv; lat = l; respEnable = 1'b1;
    clearObs();
    foreach (s[i]) applyStimulus(1, s[i].t, s[i].d, 0, 0);
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput({tag, "_count_pre"}, o_count, s.size());
    waitDone(n0);
    buildModel(s, n0, l, rv);
    compareRun(tag);
    checkOutput({tag, "_post"}, {o_count, o_empty, o_busy, o_error}, {5'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ent_t s[$];
    int n0;
    repeat (2) applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput("reset_outs", {o_full, o_busy, o_done, o_error, o_overflow, o_rd_stb, o_cmd_write_stb,
                o_cmd_read_stb, o_cmd_parameter, o_enable, o_rd_data, o_cmd_data}, 0);
    checkOutput("reset_fifo", {o_empty, o_count}, {1'b1, 5'd0});
    rst_n = 1'b1;
    repeat (2) applyStimulus(0, 2'd0, 8'd0, 0, 0);

    s = {mk(0, 8'h2A), mk(1, 8'h00), mk(1, 8'hEF)};
    runScript("writes", s, 2, 8'h00);
    s = {mk(2, 8'h00)};
    runScript("read", s, 3, 8'h5C);
    checkOutput("read_value", o_rd_data, 8'h5C);
    s = {mk(3, 8'd2), mk(0, 8'h29)};
    runScript("delay", s, 2, 8'h00);

    for (int r = 0; r < 10; r++) begin
      ent_t e;
      s.delete();
      for (int i = 0; i < $urandom_range(12, 1); i++) begin
        e.t = 2'($urandom_range(3, 0));
        e.d = (e.t == 2'd3) ? 8'($urandom_range(3, 0)) : 8'($urandom_range(255, 0));
        s.push_back(e);
      end
      runScript($sformatf("rand%0d", r), s, $urandom_range(4, 1), 8'($urandom));
    end

    // Responder silent: first write times out, remaining entries are flushed.
    respEnable = 1'b0;
    clearObs();
    applyStimulus(1, 2'd0, 8'h11, 0, 0);
    applyStimulus(1, 2'd0, 8'h22, 0, 0);
    applyStimulus(1, 2'd0, 8'h33, 0, 0);
    waitDone(n0);
    checkOutput("tmo_ntxn", obsTxn.size(), 1);
    if (obsTxn.size() > 0) checkOutput("tmo_strobe_cyc", obsTxn[0].c, n0 + 2);
    checkOutput("tmo_ndone", obsDone.size(), 1);
    if (obsDone.size() > 0) checkOutput("tmo_done_cyc", obsDone[0], n0 + 3 + TMO);
    checkOutput("tmo_flags", {o_error, o_empty, o_count}, {1'b1, 1'b1, 5'd0});

    clearObs();
    waitDone(n0);
    checkOutput("empty_ntxn", obsTxn.size(), 0);
    checkOutput("empty_ndone", obsDone.size(), 1);
    if (obsDone.size() > 0) checkOutput("empty_done_cyc", obsDone[0], n0 + 1);
    checkOutput("empty_err_cleared", o_error, 1'b0);

    clearObs();
    applyStimulus(1, 2'd2, 8'h00, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 2'd0, 8'(i), 0, 0);
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput("ovf_flags", {o_full, o_overflow, o_count}, {1'b1, 1'b1, 5'd16});
    applyStimulus(0, 2'd0, 8'd0, 1, 0);
    n0 = cyc;
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput("ovf_cleared", {o_overflow, o_busy}, {1'b0, 1'b1});
    repeat (3) applyStimulus(0, 2'd0, 8'd0, 0, 0);
    applyStimulus(0, 2'd0, 8'd0, 0, 1);
    forceFin = 1'b1; forceData = 8'h77;
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    forceFin = 1'b0;
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    forceFin = 1'b1;
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    forceFin = 1'b0;
    repeat (4) applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput("abort_ntxn", obsTxn.size(), 1);
    if (obsTxn.size() > 0) checkOutput("abort_first_cyc", obsTxn[0].c, n0 + 2);
    checkOutput("abort_nrd", obsRd.size(), 0);
    checkOutput("abort_ndone", obsDone.size(), 1);
    if (obsDone.size() > 0) checkOutput("abort_done_cyc", obsDone[0], n0 + 6);
    checkOutput("abort_fifo", {o_empty, o_count, o_busy}, {1'b1, 5'd0, 1'b0});

    respEnable = 1'b1; lat = 3;
    clearObs();
    applyStimulus(1, 2'd0, 8'h55, 0, 0);
    applyStimulus(1, 2'd1, 8'h66, 0, 0);
    applyStimulus(0, 2'd0, 8'd0, 1, 0);
    for (int k = 0; k < 20 && !o_cmd_write_stb; k++) applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput("rst_pre_strobe", o_cmd_write_stb, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_outs", {o_full, o_busy, o_done, o_error, o_overflow, o_rd_stb, o_cmd_write_stb,
                o_cmd_read_stb, o_cmd_parameter, o_enable, o_rd_data, o_cmd_data}, 0);
    checkOutput("rst_mid_fifo", {o_empty, o_count}, {1'b1, 5'd0});
    applyStimulus(0, 2'd0, 8'd0, 0, 0);
    rst_n = 1'b1;
    repeat (6) applyStimulus(0, 2'd0, 8'd0, 0, 0);
    checkOutput("rst_after_idle", {o_busy, o_empty}, {1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
